mul_product_accumulator: RTL and testbench
==========================================

Name: mul_product_accumulator

Overview:
- Downstream stage of the parameterized multiplier: consumes its unsigned product `y` (A_WIDTH+B_WIDTH bits) through a valid/ready handshake.
- Sums exactly COUNT products per frame into an ACC_WIDTH accumulator, with saturation and a sticky overflow flag.
- Presents each frame total to the next stage on a valid/ready output held until taken.
- Sits between the multiplier and the filter/dot-product result logic.

Parameters:
- A_WIDTH, 8, width of multiplier operand a1.
- B_WIDTH, 8, width of multiplier operand b; product width P_WIDTH = A_WIDTH+B_WIDTH (localparam).
- ACC_WIDTH, 32, accumulator and result width; must be >= P_WIDTH.
- COUNT, 16, products per frame; must be >= 1. Counter width is a localparam, clog2(COUNT) min 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous discard of the partial frame.
- p_valid  input  1  product valid.
- p_data  input  P_WIDTH  unsigned product from the multiplier.
- p_ready  output  1  block accepts p_data this cycle.
- acc_valid  output  1  frame result valid.
- acc_data  output  ACC_WIDTH  frame sum, saturated.
- acc_ovf  output  1  frame saturated at least once.
- acc_ready  input  1  downstream accepts the result.

Behaviour:
- Reset (rst=1, asynchronous, immediate):
  - State ACC; accumulator = 0, cnt = 0.
  - acc_valid = 0, acc_data = 0, acc_ovf = 0.
  - p_ready = 1 after rst deasserts.
  - Any partial frame or unconsumed result is lost.
- States are ACC and HOLD; state is registered. p_ready = (state==ACC), decoded combinationally from state only.
- ACC, beat accepted (p_valid & p_ready & !clr):
  - sum = acc + zero-extend(p_data), computed ACC_WIDTH+1 bits wide.
  - If bit ACC_WIDTH is set, or the frame's sticky ovf is already set: acc_next = all ones and ovf_next = 1. Otherwise acc_next = sum[ACC_WIDTH-1:0].
  - If cnt != COUNT-1: acc <= acc_next, cnt <= cnt+1.
  - If cnt == COUNT-1 (last beat):
    - acc_data <= acc_next, acc_ovf <= ovf_next, acc_valid <= 1.
    - acc <= 0, sticky ovf <= 0, cnt <= 0, state <= HOLD.
  - Result latency: acc_valid rises on the clock edge that accepts the last beat, so it is visible the next cycle.
- ACC, no beat (p_valid=0): all state is held. Gaps between beats are allowed and do not affect the sum.
- clr in ACC: acc, cnt and sticky ovf are reset to 0. If clr coincides with p_valid, clr wins: the beat is dropped, but the handshake still completes because p_ready=1.
- clr in HOLD: ignored. The held result is not affected.
- HOLD:
  - p_ready = 0.
  - acc_valid, acc_data and acc_ovf are held stable while acc_ready = 0.
  - On acc_valid & acc_ready: acc_valid <= 0, state <= ACC.
  - A new beat can be accepted in the cycle after the result handshake.
  - acc_data and acc_ovf keep their last value after the handshake; only acc_valid drops.
- Throughput: one frame per COUNT+1 cycles minimum (COUNT beats plus one HOLD cycle with acc_ready=1).
- COUNT=1: every accepted beat produces a result and enters HOLD.
- Inputs are unsigned only; no signed mode.
- No combinational path from p_valid or acc_ready to any output.

Test Plan:
1. Defaults; p_data = 1..16 on consecutive cycles, acc_ready=1 -> acc_valid=1 for exactly one cycle, starting the cycle after the 16th beat; acc_data=136, acc_ovf=0; p_ready=0 in that cycle, then 1 again.
2. Defaults; 16 beats of 65025 with p_valid toggling every other cycle -> acc_data=1040400, acc_ovf=0; beat spacing does not change the result.
3. Defaults; full frame, then acc_ready=0 for 5 cycles -> acc_valid, acc_data and p_ready=0 stable for all 5 cycles; result consumed on the 6th cycle; the next frame of 16 beats of 2 -> 32.
4. ACC_WIDTH=17, COUNT=4; 4 beats of 65025 -> acc_data=131071, acc_ovf=1. The following frame of 4 beats of 1 -> acc_data=4, acc_ovf=0 (sticky cleared per frame).
5. Defaults; 3 beats of 100, then clr together with p_valid and p_data=7, then 16 beats of 1 -> acc_data=16; the 100s and the 7 are excluded.
6. Defaults; rst pulsed asynchronously (between clock edges) after 10 beats, and again while in HOLD -> acc_valid, acc_data and acc_ovf go to 0 immediately; p_ready=1 after release; the next 16 beats of 3 -> 48.

Source files
------------

// File: rtl/mul_product_accumulator.sv
// Frame accumulator behind the multiplier: sums COUNT unsigned products with
// saturation and a per-frame sticky overflow, then holds the total until taken.
module mul_product_accumulator #(
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned B_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned COUNT     = 16,
  localparam int unsigned P_WIDTH  = A_WIDTH + B_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 p_valid,
  input  logic [P_WIDTH-1:0]   p_data,
  output logic                 p_ready,
  output logic                 acc_valid,
  output logic [ACC_WIDTH-1:0] acc_data,
  output logic                 acc_ovf,
  input  logic                 acc_ready
);

  localparam int unsigned CNT_WIDTH = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(COUNT - 1);

  typedef enum logic {ACC, HOLD} state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 ovf;

  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 ovf_next;
  logic                 beat;

  assign p_ready = (state == ACC);
  assign beat    = p_valid & p_ready & ~clr;

  // Once the frame has saturated it stays pinned at all ones until the frame ends.
  always_comb begin
    sum      = {1'b0, acc} + (ACC_WIDTH + 1)'(p_data);
    acc_next = sum[ACC_WIDTH-1:0];
    ovf_next = ovf;
    if (sum[ACC_WIDTH] || ovf) begin
      acc_next = '1;
      ovf_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      acc_valid <= 1'b0;
      acc_data  <= '0;
      acc_ovf   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (clr) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
          end else if (beat) begin
            if (cnt == CNT_LAST) begin
              acc_data  <= acc_next;
              acc_ovf   <= ovf_next;
              acc_valid <= 1'b1;
              acc       <= '0;
              ovf       <= 1'b0;
              cnt       <= '0;
              state     <= HOLD;
            end else begin
              acc <= acc_next;
              ovf <= ovf_next;
              cnt <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (acc_ready) begin
            acc_valid <= 1'b0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_product_accumulator.sv
// Directed bench: default-parameter instance plus a narrow ACC_WIDTH=17, COUNT=4
// instance for saturation; all expected values are hand-computed constants.
module tb_mul_product_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        clr = 1'b0;
  logic        p_valid = 1'b0;
  logic [15:0] p_data = '0;
  logic        p_ready;
  logic        acc_valid;
  logic [31:0] acc_data;
  logic        acc_ovf;
  logic        acc_ready = 1'b1;

  logic        s_clr = 1'b0;
  logic        s_p_valid = 1'b0;
  logic [15:0] s_p_data = '0;
  logic        s_p_ready;
  logic        s_acc_valid;
  logic [16:0] s_acc_data;
  logic        s_acc_ovf;
  logic        s_acc_ready = 1'b1;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  mul_product_accumulator u_dut (
    .clk(clk), .rst(rst), .clr(clr),
    .p_valid(p_valid), .p_data(p_data), .p_ready(p_ready),
    .acc_valid(acc_valid), .acc_data(acc_data), .acc_ovf(acc_ovf),
    .acc_ready(acc_ready)
  );

  mul_product_accumulator #(.ACC_WIDTH(17), .COUNT(4)) u_small (
    .clk(clk), .rst(rst), .clr(s_clr),
    .p_valid(s_p_valid), .p_data(s_p_data), .p_ready(s_p_ready),
    .acc_valid(s_acc_valid), .acc_data(s_acc_data), .acc_ovf(s_acc_ovf),
    .acc_ready(s_acc_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic send(input logic [15:0] d);
    p_valid = 1'b1;
    p_data  = d;
    @(negedge clk);
    p_valid = 1'b0;
  endtask

  task automatic send_s(input logic [15:0] d);
    s_p_valid = 1'b1;
    s_p_data  = d;
    @(negedge clk);
    s_p_valid = 1'b0;
  endtask

  task automatic frame(input logic [15:0] d);
    for (int i = 0; i < 16; i++) send(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    #2;
    check("rst_valid", 32'(acc_valid), 32'd0);
    check("rst_data", acc_data, 32'd0);
    check("rst_ovf", 32'(acc_ovf), 32'd0);
    check("rst_s_valid", 32'(s_acc_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_p_ready", 32'(p_ready), 32'd1);

    // 1: 1..16 back to back -> 136
    for (int i = 0; i < 16; i++) begin
      send(16'(i + 1));
      check("t1_valid_timing", 32'(acc_valid), (i == 15) ? 32'd1 : 32'd0);
    end
    check("t1_data", acc_data, 32'd136);
    check("t1_ovf", 32'(acc_ovf), 32'd0);
    check("t1_p_ready_hold", 32'(p_ready), 32'd0);
    @(negedge clk);
    check("t1_valid_drop", 32'(acc_valid), 32'd0);
    check("t1_p_ready_back", 32'(p_ready), 32'd1);
    check("t1_data_kept", acc_data, 32'd136);

    // 2: 16 x 65025 with gaps -> 1040400
    for (int i = 0; i < 16; i++) begin
      send(16'd65025);
      if (i < 15) begin
        check("t2_no_early_valid", 32'(acc_valid), 32'd0);
        @(negedge clk);
      end
    end
    check("t2_valid", 32'(acc_valid), 32'd1);
    check("t2_data", acc_data, 32'd1040400);
    check("t2_ovf", 32'(acc_ovf), 32'd0);
    @(negedge clk);

    // 3: backpressure for 5 cycles, clr during HOLD ignored
    acc_ready = 1'b0;
    frame(16'd10);
    for (int k = 0; k < 5; k++) begin
      check("t3_valid_stable", 32'(acc_valid), 32'd1);
      check("t3_data_stable", acc_data, 32'd160);
      check("t3_p_ready_low", 32'(p_ready), 32'd0);
      clr = (k < 2);
      @(negedge clk);
    end
    clr = 1'b0;
    check("t3_valid_6th", 32'(acc_valid), 32'd1);
    acc_ready = 1'b1;
    @(negedge clk);
    check("t3_consumed", 32'(acc_valid), 32'd0);
    frame(16'd2);
    check("t3_next_valid", 32'(acc_valid), 32'd1);
    check("t3_next_data", acc_data, 32'd32);
    @(negedge clk);

    // 4: narrow accumulator saturates, sticky flag cleared per frame
    for (int i = 0; i < 4; i++) send_s(16'd65025);
    check("t4_valid", 32'(s_acc_valid), 32'd1);
    check("t4_sat_data", 32'(s_acc_data), 32'd131071);
    check("t4_sat_ovf", 32'(s_acc_ovf), 32'd1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) send_s(16'd1);
    check("t4_next_valid", 32'(s_acc_valid), 32'd1);
    check("t4_next_data", 32'(s_acc_data), 32'd4);
    check("t4_next_ovf", 32'(s_acc_ovf), 32'd0);
    @(negedge clk);

    // 5: clr wins over a coincident beat
    for (int i = 0; i < 3; i++) send(16'd100);
    clr = 1'b1;
    p_valid = 1'b1;
    p_data = 16'd7;
    check("t5_p_ready_clr", 32'(p_ready), 32'd1);
    @(negedge clk);
    clr = 1'b0;
    p_valid = 1'b0;
    frame(16'd1);
    check("t5_valid", 32'(acc_valid), 32'd1);
    check("t5_data", acc_data, 32'd16);
    check("t5_ovf", 32'(acc_ovf), 32'd0);
    @(negedge clk);

    // 6a: async reset mid-frame
    for (int i = 0; i < 10; i++) send(16'd5);
    #2 rst = 1'b1;
    #1;
    check("t6_mid_data", acc_data, 32'd0);
    check("t6_mid_valid", 32'(acc_valid), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t6_mid_p_ready", 32'(p_ready), 32'd1);
    frame(16'd3);
    check("t6_mid_next_data", acc_data, 32'd48);
    check("t6_mid_next_valid", 32'(acc_valid), 32'd1);
    @(negedge clk);

    // 6b: async reset while holding a saturated-free result
    acc_ready = 1'b0;
    frame(16'd9);
    check("t6_hold_data_pre", acc_data, 32'd144);
    #2 rst = 1'b1;
    #1;
    check("t6_hold_valid", 32'(acc_valid), 32'd0);
    check("t6_hold_data", acc_data, 32'd0);
    check("t6_hold_ovf", 32'(acc_ovf), 32'd0);
    #1 rst = 1'b0;
    acc_ready = 1'b1;
    @(negedge clk);
    check("t6_hold_p_ready", 32'(p_ready), 32'd1);
    frame(16'd3);
    check("t6_hold_next_valid", 32'(acc_valid), 32'd1);
    check("t6_hold_next_data", acc_data, 32'd48);
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
